// File: rtl/red_digit.sv
// GF(2) polynomial reducer: computes reduc_in mod P for a run-time selectable
// reduction polynomial P of degree m <= DATA_WIDTH.
// DIGIT leading positions of the remainder are eliminated per RUN cycle.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for op_enable; request latched on the accept edge
// S_RUN  | eliminating DIGIT remainder positions per cycle
// S_DONE | single cycle; op_finish pulses on the edge that leaves it
module red_digit #(
   parameter int DATA_WIDTH = 8,
   parameter int DIGIT      = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            op_enable,
   input  logic [$clog2(DATA_WIDTH):0]     polyn_grade,
   input  logic [DATA_WIDTH:0]             polyn_red_in,
   input  logic [2*DATA_WIDTH-1:0]         reduc_in,
   output logic [DATA_WIDTH-1:0]           out,
   output logic                            op_finish,
   output logic                            busy,
   output logic                            op_error
);

   localparam int W2  = 2 * DATA_WIDTH;
   localparam int GW  = $clog2(DATA_WIDTH) + 1;
   localparam int GW1 = GW + 1;
   localparam int IW  = $clog2(W2);
   localparam int CW  = IW + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_nxt;

   logic [GW-1:0]         grade_q;
   logic [DATA_WIDTH:0]   poly_q;
   logic [W2-1:0]         rem_q;
   logic [IW-1:0]         idx_q;
   logic [CW-1:0]         pos_q;
   logic [DATA_WIDTH-1:0] out_q;
   logic                  err_q;
   logic                  fin_q;

   logic [DATA_WIDTH:0]   poly_mask;
   logic [DATA_WIDTH:0]   lead_onehot;
   logic                  grade_ok;
   logic                  req_valid;
   logic [CW-1:0]         pos_load;
   logic                  accept;
   logic                  run_last;

   logic [W2-1:0]         rem_nxt;
   logic [W2-1:0]         poly_ext;
   logic [IW-1:0]         j_pos;
   logic [IW-1:0]         sh_amt;

   // Request qualification: degree in range and its leading coefficient set.
   // Coefficients above the degree are masked off so they never reach the datapath.
   always_comb begin
      poly_mask   = ~({(DATA_WIDTH+1){1'b1}} << polyn_grade << 1);
      lead_onehot = {{DATA_WIDTH{1'b0}}, 1'b1} << polyn_grade;
      grade_ok    = (polyn_grade != '0) &&
                    ({1'b0, polyn_grade} <= GW1'(DATA_WIDTH));
      req_valid   = grade_ok && (|(polyn_red_in & lead_onehot));
      pos_load    = CW'(W2) - CW'(polyn_grade);
      accept      = (state_q == S_IDLE) && op_enable;
      // pos_q counts remaining positions >= m; last cycle when DIGIT or fewer remain
      run_last    = (state_q == S_RUN) && (pos_q <= CW'(DIGIT));
   end

   // One RUN step: eliminate positions idx_q downto max(idx_q-DIGIT+1, m),
   // each XOR feeding the next so a cleared bit can create lower set bits.
   always_comb begin
      rem_nxt  = rem_q;
      poly_ext = W2'(poly_q);
      j_pos    = '0;
      sh_amt   = '0;
      for (int k = 0; k < DIGIT; k++) begin
         if ({1'b0, idx_q} >= (CW'(k) + {1'b0, grade_q})) begin
            j_pos  = idx_q - IW'(k);
            sh_amt = j_pos - IW'(grade_q);
            if (rem_nxt[j_pos]) begin
               rem_nxt = rem_nxt ^ (poly_ext << sh_amt);
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state logic and busy flag.
   always_comb begin
      state_nxt = state_q;
      busy      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (op_enable) begin
               state_nxt = req_valid ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (run_last) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Operand latch, remainder/index/position update and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grade_q <= '0;
         poly_q  <= '0;
         rem_q   <= '0;
         idx_q   <= '0;
         pos_q   <= '0;
         out_q   <= '0;
         err_q   <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         fin_q <= (state_q == S_DONE);
         if (accept) begin
            grade_q <= polyn_grade;
            poly_q  <= polyn_red_in & poly_mask;
            rem_q   <= reduc_in;
            idx_q   <= IW'(W2 - 1);
            pos_q   <= pos_load;
            err_q   <= ~req_valid;
            // a valid request keeps the previous result visible until RUN ends
            if (!req_valid) begin
               out_q <= '0;
            end
         end else if (state_q == S_RUN) begin
            rem_q <= rem_nxt;
            idx_q <= idx_q - IW'(DIGIT);
            pos_q <= pos_q - CW'(DIGIT);
            if (run_last) begin
               out_q <= rem_nxt[DATA_WIDTH-1:0];
            end
         end
      end
   end

   assign out       = out_q;
   assign op_finish = fin_q;
   assign op_error  = err_q;

endmodule

// File: tb/tb_red_digit.sv
// Directed bench for red_digit: one instance with DIGIT=1 and one with DIGIT=4
// share the same stimulus; latency, result, error flag and pulse width are
// compared against hand-computed values.
module tb_red_digit;

   logic        clk;
   logic        rst;
   logic        op_enable;
   logic [3:0]  polyn_grade;
   logic [8:0]  polyn_red_in;
   logic [15:0] reduc_in;

   logic [7:0]  out1, out4;
   logic        fin1, fin4, busy1, busy4, err1, err4;

   int checks;
   int failures;

   red_digit #(.DATA_WIDTH(8), .DIGIT(1)) u_dut1 (
      .clk          (clk),
      .rst          (rst),
      .op_enable    (op_enable),
      .polyn_grade  (polyn_grade),
      .polyn_red_in (polyn_red_in),
      .reduc_in     (reduc_in),
      .out          (out1),
      .op_finish    (fin1),
      .busy         (busy1),
      .op_error     (err1)
   );

   red_digit #(.DATA_WIDTH(8), .DIGIT(4)) u_dut4 (
      .clk          (clk),
      .rst          (rst),
      .op_enable    (op_enable),
      .polyn_grade  (polyn_grade),
      .polyn_red_in (polyn_red_in),
      .reduc_in     (reduc_in),
      .out          (out4),
      .op_finish    (fin4),
      .busy         (busy4),
      .op_error     (err4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Issue one request, scramble inputs right after the accept edge, then
   // watch 40 cycles for the finish pulse of both instances.
   task automatic run_op(input string tag, input logic [3:0] g, input logic [8:0] p,
                         input logic [15:0] r, input logic [7:0] exp_out,
                         input logic exp_err, input int lat1, input int lat4);
      int n1, n4, w1, w4;
      logic [7:0] o1, o4;
      logic e1, e4;
      n1 = 0; n4 = 0; w1 = 0; w4 = 0;
      o1 = '0; o4 = '0; e1 = 1'b0; e4 = 1'b0;
      @(negedge clk);
      op_enable    = 1'b1;
      polyn_grade  = g;
      polyn_red_in = p;
      reduc_in     = r;
      @(posedge clk);
      #1;
      op_enable    = 1'b0;
      polyn_grade  = ~g;
      polyn_red_in = ~p;
      reduc_in     = ~r;
      chk_eq({tag, "_busy"}, busy1, 1);
      chk_eq({tag, "_err_acc"}, err1, exp_err);
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (fin1) begin
            w1++;
            if (n1 == 0) begin
               n1 = c; o1 = out1; e1 = err1;
            end
         end
         if (fin4) begin
            w4++;
            if (n4 == 0) begin
               n4 = c; o4 = out4; e4 = err4;
            end
         end
      end
      chk_eq({tag, "_lat1"}, n1, lat1);
      chk_eq({tag, "_out1"}, o1, exp_out);
      chk_eq({tag, "_err1"}, e1, exp_err);
      chk_eq({tag, "_width1"}, w1, 1);
      chk_eq({tag, "_lat4"}, n4, lat4);
      chk_eq({tag, "_out4"}, o4, exp_out);
      chk_eq({tag, "_err4"}, e4, exp_err);
      chk_eq({tag, "_width4"}, w4, 1);
      chk_eq({tag, "_hold1"}, out1, exp_out);
   endtask

   initial begin
      int n1, p1, h1, p4, h4;
      logic prev1, prev4;
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      op_enable    = 1'b0;
      polyn_grade  = '0;
      polyn_red_in = '0;
      reduc_in     = '0;
      #2;
      chk_eq("reset_dut1", {out1, fin1, busy1, err1}, 0);
      chk_eq("reset_dut4", {out4, fin4, busy4, err4}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      //      tag          m      P       reduc_in   out    err lat1 lat4
      run_op("t031",     4'd4, 9'h013, 16'd90,    8'd5,  0,  13,  4);
      run_op("t033",     4'd3, 9'h00B, 16'd27,    8'd6,  0,  14,  5);
      run_op("aes",      4'd8, 9'h11B, 16'h2B79,  8'hC1, 0,  9,   3);
      run_op("inv_lead", 4'd4, 9'h003, 16'd90,    8'd0,  1,  1,   1);
      run_op("mask",     4'd4, 9'h1F3, 16'd90,    8'd5,  0,  13,  4);
      run_op("inv_g9",   4'd9, 9'h1FF, 16'd90,    8'd0,  1,  1,   1);
      run_op("low_deg",  4'd8, 9'h11B, 16'h0057,  8'h57, 0,  9,   3);
      run_op("inv_g0",   4'd0, 9'h013, 16'd90,    8'd0,  1,  1,   1);
      run_op("m1",       4'd1, 9'h003, 16'h8000,  8'd1,  0,  16,  5);
      run_op("m5",       4'd5, 9'h025, 16'h0100,  8'h0D, 0,  12,  4);

      // Reset in the middle of a DIGIT=1 run, then accept on the first edge after release.
      @(negedge clk);
      op_enable    = 1'b1;
      polyn_grade  = 4'd4;
      polyn_red_in = 9'h013;
      reduc_in     = 16'd90;
      @(posedge clk);
      #1;
      op_enable = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk_eq("rst_pre_busy", busy1, 1);
      #1;
      rst = 1'b1;
      #1;
      chk_eq("rst_busy1", busy1, 0);
      chk_eq("rst_out1", out1, 0);
      chk_eq("rst_fin1", fin1, 0);
      chk_eq("rst_out4", out4, 0);
      @(negedge clk);
      rst          = 1'b0;
      op_enable    = 1'b1;
      polyn_grade  = 4'd3;
      polyn_red_in = 9'h00B;
      reduc_in     = 16'd27;
      @(posedge clk);
      #1;
      op_enable = 1'b0;
      chk_eq("post_rst_busy", busy1, 1);
      n1 = 0;
      h1 = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (fin1) begin
            h1++;
            if (n1 == 0) n1 = c;
         end
      end
      chk_eq("post_rst_lat1", n1, 14);
      chk_eq("post_rst_pulses1", h1, 1);
      chk_eq("post_rst_out1", out1, 6);

      // op_enable held high: back-to-back operations, single-cycle pulses.
      @(negedge clk);
      op_enable    = 1'b1;
      polyn_grade  = 4'd4;
      polyn_red_in = 9'h013;
      reduc_in     = 16'd90;
      p1 = 0; h1 = 0; p4 = 0; h4 = 0;
      prev1 = 1'b0; prev4 = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk);
         #1;
         if (fin1) begin
            h1++;
            if (!prev1) p1++;
            chk_eq("b2b_out1", out1, 5);
         end
         if (fin4) begin
            h4++;
            if (!prev4) p4++;
            chk_eq("b2b_out4", out4, 5);
         end
         prev1 = fin1;
         prev4 = fin4;
      end
      chk_eq("b2b_pulses1", p1, 2);
      chk_eq("b2b_high1", h1, 2);
      chk_eq("b2b_pulses4", p4, 6);
      chk_eq("b2b_high4", h4, 6);
      @(negedge clk);
      op_enable = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk_eq("final_idle1", busy1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/red_digit.md
RED_DIGIT -- requirements
Module: red_digit

Interface
REQ-001 Parameter DATA_WIDTH, default 8: maximum field degree m; operand-out width.
REQ-002 Parameter DIGIT, default 1: bit positions eliminated per compute cycle, legal range 1..DATA_WIDTH.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 op_enable  in  1  start request, sampled only in IDLE.
REQ-006 polyn_grade  in  $clog2(DATA_WIDTH)+1  degree m of the reduction polynomial.
REQ-007 polyn_red_in  in  DATA_WIDTH+1  reduction polynomial P; bit k is the coefficient of x^k.
REQ-008 reduc_in  in  2*DATA_WIDTH  GF(2) polynomial to reduce.
REQ-009 out  out  DATA_WIDTH  remainder reduc_in mod P.
REQ-010 op_finish  out  1  one-cycle completion pulse.
REQ-011 busy  out  1  high in RUN and DONE.
REQ-012 op_error  out  1  invalid-polynomial flag for the last operation.

Function
REQ-013 The state machine SHALL have states IDLE, RUN and DONE.
REQ-014 IDLE with op_enable=1 at a rising edge SHALL accept: latch polyn_grade, polyn_red_in and reduc_in into internal registers, clear op_error, and go to RUN.
REQ-015 Input changes after the accept edge SHALL have no effect on the operation in progress.
REQ-016 Invalid request: polyn_grade=0, polyn_grade>DATA_WIDTH, or polyn_red_in[polyn_grade]=0. It SHALL go IDLE->DONE directly with op_error=1 and out=0.
REQ-017 Bits of polyn_red_in above polyn_grade SHALL be ignored (masked at latch).
REQ-018 RUN SHALL hold a 2*DATA_WIDTH remainder R and a scan index i, starting at i=2*DATA_WIDTH-1.
REQ-019 Each RUN cycle SHALL process positions j = i down to max(i-DIGIT+1, m) in descending order. For each j with R[j]=1 it SHALL apply R ^= P<<(j-m), chained combinationally within the cycle. Then i -= DIGIT.
REQ-020 RUN SHALL last exactly C = ceil((2*DATA_WIDTH-m)/DIGIT) cycles, then go to DONE.
REQ-021 DONE SHALL last one cycle with op_finish=1, then go to IDLE.
REQ-022 op_finish SHALL rise C+1 cycles after the accept edge for a valid request, and 1 cycle after it for an invalid request.
REQ-023 On leaving RUN, out SHALL equal R[DATA_WIDTH-1:0], with all bits at index >= m equal to 0.
REQ-024 out and op_error SHALL hold their values from DONE until the next accept edge.
REQ-025 op_enable SHALL be ignored while busy=1.
REQ-026 If op_enable is held high, the next operation SHALL be accepted on the first IDLE cycle after DONE.
REQ-027 An input of degree < m SHALL still take C cycles and return reduc_in[DATA_WIDTH-1:0] unchanged.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE, with out=0, op_finish=0, busy=0, op_error=0, and all internal registers 0.
REQ-029 Reset during RUN or DONE SHALL abort the operation with no op_finish pulse.
REQ-030 After rst falls, the first accept SHALL be possible at the next rising edge.

Verification
REQ-031 DATA_WIDTH=8, DIGIT=1, m=4, P=19, reduc_in=90, op_enable=1 -> op_finish 13 cycles after accept, out=5, op_error=0.
REQ-032 DIGIT=4, same stimulus as REQ-031 -> op_finish 4 cycles after accept, out=5.
REQ-033 DIGIT=1, m=3, P=11, reduc_in=27 -> op_finish 14 cycles after accept, out=6.
REQ-034 DIGIT=1, m=8, P=0x11B, reduc_in=0x2B79 (product of 0x57 and 0x83) -> out=0xC1 after 9 cycles.
REQ-035 m=4, P=3 (bit 4 clear) -> op_finish 1 cycle after accept, op_error=1, out=0. A following valid request clears op_error.
REQ-036 Reduction scenarios:
- rst pulsed mid-RUN -> busy=0, out=0, no op_finish pulse.
- op_enable held high for 30 cycles -> back-to-back operations, each op_finish exactly one cycle wide.
